// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: per-read-port forwarding selects across NFWD stages plus a
// busy-register scoreboard for long-latency writers. O_stall combines
// load-use, scoreboard RAW and scoreboard WAW hazards.
// Optional build macro FWD_SB_PERF_CNT_EN adds load-use / scoreboard stall
// cycle counters (O_lu_stall_cnt, O_sb_stall_cnt).
module fwd_scoreboard #(
  parameter int NRD  = 2,
  parameter int NFWD = 2,
  parameter int AW   = 5,
  parameter int SELW = $clog2(NFWD+2),
  parameter int CNTW = 6
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic [NRD-1:0]       I_rd_re,
  input  logic [NRD*AW-1:0]    I_rd_raddr,
  input  logic [NFWD-1:0]      I_fwd_we,
  input  logic [NFWD*AW-1:0]   I_fwd_waddr,
  input  logic [NFWD-1:0]      I_fwd_rdy,
  input  logic                 I_id_fire,
  input  logic                 I_id_rd_we,
  input  logic [AW-1:0]        I_id_rd_waddr,
  input  logic                 I_id_long,
  input  logic                 I_lc_valid,
  input  logic [AW-1:0]        I_lc_waddr,
  output logic [NRD*SELW-1:0]  O_fwd_sel,
  output logic                 O_stall,
  output logic [(2**AW)-1:0]   O_busy,
  output logic [CNTW-1:0]      O_pending,
`ifdef FWD_SB_PERF_CNT_EN
  output logic [31:0]          O_lu_stall_cnt,
  output logic [31:0]          O_sb_stall_cnt,
`endif
  output logic                 O_sb_err
);

  localparam int NREG = 2**AW;

  logic [NREG-1:0] busy_q, busy_nxt;
  logic [CNTW-1:0] pending_q, pending_nxt;
  logic            err_q, err_nxt;

  logic [NRD-1:0]  lu_hit;
  logic [NRD-1:0]  raw_hit;
  logic            waw_hit;
  logic            lu_any;
  logic            sb_any;

  // Forward select per read port (youngest matching stage wins) plus
  // per-port load-use and scoreboard RAW detection.
  always_comb begin
    O_fwd_sel = '0;
    lu_hit    = '0;
    raw_hit   = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0]   raddr;
      logic [SELW-1:0] sel;
      logic            lu;
      raddr = I_rd_raddr[k*AW +: AW];
      sel   = SELW'(1);
      lu    = 1'b0;
      for (int j = NFWD-1; j >= 0; j--) begin
        if (I_fwd_we[j] && (I_fwd_waddr[j*AW +: AW] == raddr)) begin
          sel = SELW'(j + 2);
          lu  = !I_fwd_rdy[j];
        end
      end
      if (!I_rd_re[k] || (raddr == '0)) begin
        sel = '0;
        lu  = 1'b0;
      end
      O_fwd_sel[k*SELW +: SELW] = sel;
      lu_hit[k]  = lu;
      raw_hit[k] = I_rd_re[k] && (raddr != '0) && busy_q[raddr];
    end
  end

  // Hazard summary; stall uses registered busy only, so a consumer is held
  // through the completion cycle and released the cycle after.
  always_comb begin
    waw_hit = I_id_rd_we && (I_id_rd_waddr != '0) && busy_q[I_id_rd_waddr];
    lu_any  = |lu_hit;
    sb_any  = (|raw_hit) || waw_hit;
    O_stall = lu_any || sb_any;
  end

  // Scoreboard next state: set on issue of a long op, clear on completion,
  // flag protocol violations.
  always_comb begin
    logic set_req, clr_ok, set_eff;
    busy_nxt    = busy_q;
    pending_nxt = pending_q;
    err_nxt     = err_q;
    set_req = I_id_fire && !O_stall && I_id_long && I_id_rd_we &&
              (I_id_rd_waddr != '0);
    clr_ok  = I_lc_valid && (I_lc_waddr != '0) && busy_q[I_lc_waddr];
    set_eff = set_req;
    if (I_id_fire && O_stall) err_nxt = 1'b1;
    if (I_lc_valid && !clr_ok) err_nxt = 1'b1;
    // Same register set and cleared together: keep the clear, drop the set.
    if (set_req && I_lc_valid && (I_lc_waddr == I_id_rd_waddr)) begin
      set_eff = 1'b0;
      err_nxt = 1'b1;
    end
    if (clr_ok)  busy_nxt[I_lc_waddr]    = 1'b0;
    if (set_eff) busy_nxt[I_id_rd_waddr] = 1'b1;
    if (set_eff && !clr_ok && (pending_q != {CNTW{1'b1}}))
      pending_nxt = pending_q + 1'b1;
    else if (clr_ok && !set_eff && (pending_q != '0))
      pending_nxt = pending_q - 1'b1;
  end

  // Scoreboard state registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_nxt;
      pending_q <= pending_nxt;
      err_q     <= err_nxt;
    end
  end

  assign O_busy    = busy_q;
  assign O_pending = pending_q;
  assign O_sb_err  = err_q;

`ifdef FWD_SB_PERF_CNT_EN
  logic [31:0] lu_cnt_q, sb_cnt_q;

  // Stall-cycle counters per hazard class; wrap naturally at 2^32.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      lu_cnt_q <= '0;
      sb_cnt_q <= '0;
    end else begin
      if (lu_any) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (sb_any) sb_cnt_q <= sb_cnt_q + 32'd1;
    end
  end

  assign O_lu_stall_cnt = lu_cnt_q;
  assign O_sb_stall_cnt = sb_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: behavioural model (busy array, popcount pending)
// checked every cycle, plus directed literal expectations.
module tb_fwd_scoreboard;

  localparam int NRD  = 2;
  localparam int NFWD = 2;
  localparam int AW   = 5;
  localparam int SELW = 2;
  localparam int CNTW = 6;
  localparam int NREG = 32;

  logic I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  logic                 I_rst_n;
  logic [NRD-1:0]       I_rd_re;
  logic [NRD*AW-1:0]    I_rd_raddr;
  logic [NFWD-1:0]      I_fwd_we;
  logic [NFWD*AW-1:0]   I_fwd_waddr;
  logic [NFWD-1:0]      I_fwd_rdy;
  logic                 I_id_fire;
  logic                 I_id_rd_we;
  logic [AW-1:0]        I_id_rd_waddr;
  logic                 I_id_long;
  logic                 I_lc_valid;
  logic [AW-1:0]        I_lc_waddr;
  logic [NRD*SELW-1:0]  O_fwd_sel;
  logic                 O_stall;
  logic [NREG-1:0]      O_busy;
  logic [CNTW-1:0]      O_pending;
  logic                 O_sb_err;
`ifdef FWD_SB_PERF_CNT_EN
  logic [31:0]          O_lu_stall_cnt;
  logic [31:0]          O_sb_stall_cnt;
`endif

  fwd_scoreboard dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_rd_re(I_rd_re), .I_rd_raddr(I_rd_raddr),
    .I_fwd_we(I_fwd_we), .I_fwd_waddr(I_fwd_waddr), .I_fwd_rdy(I_fwd_rdy),
    .I_id_fire(I_id_fire), .I_id_rd_we(I_id_rd_we),
    .I_id_rd_waddr(I_id_rd_waddr), .I_id_long(I_id_long),
    .I_lc_valid(I_lc_valid), .I_lc_waddr(I_lc_waddr),
    .O_fwd_sel(O_fwd_sel), .O_stall(O_stall), .O_busy(O_busy),
    .O_pending(O_pending),
`ifdef FWD_SB_PERF_CNT_EN
    .O_lu_stall_cnt(O_lu_stall_cnt), .O_sb_stall_cnt(O_sb_stall_cnt),
`endif
    .O_sb_err(O_sb_err)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  bit          m_busy [NREG];
  bit          m_err;
  int unsigned m_lu_cnt, m_sb_cnt;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_sel(int k);
    logic [AW-1:0] a;
    a = I_rd_raddr[k*AW +: AW];
    if (!I_rd_re[k] || a == 0) return 0;
    for (int j = 0; j < NFWD; j++)
      if (I_fwd_we[j] && I_fwd_waddr[j*AW +: AW] == a) return 2 + j;
    return 1;
  endfunction

  function automatic bit exp_lu();
    for (int k = 0; k < NRD; k++) begin
      int s;
      s = exp_sel(k);
      if (s >= 2 && !I_fwd_rdy[s-2]) return 1;
    end
    return 0;
  endfunction

  function automatic bit exp_sb();
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = I_rd_raddr[k*AW +: AW];
      if (I_rd_re[k] && a != 0 && m_busy[a]) return 1;
    end
    if (I_id_rd_we && I_id_rd_waddr != 0 && m_busy[I_id_rd_waddr]) return 1;
    return 0;
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += m_busy[r];
    return n;
  endfunction

  function automatic logic [NREG-1:0] m_busy_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Model state update at each rising edge from the inputs held there.
  always @(posedge I_clk) begin
    if (!I_rst_n) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 0;
      m_err = 0; m_lu_cnt = 0; m_sb_cnt = 0;
    end else begin
      bit lu, sb, stall, do_set, do_clr;
      lu = exp_lu(); sb = exp_sb(); stall = lu || sb;
      m_lu_cnt += lu; m_sb_cnt += sb;
      if (I_id_fire && stall) m_err = 1;
      do_set = I_id_fire && !stall && I_id_long && I_id_rd_we && I_id_rd_waddr != 0;
      do_clr = 0;
      if (I_lc_valid) begin
        if (I_lc_waddr == 0 || !m_busy[I_lc_waddr]) m_err = 1;
        else do_clr = 1;
      end
      if (do_set && I_lc_valid && I_lc_waddr == I_id_rd_waddr) begin
        do_set = 0; m_err = 1;
      end
      if (do_clr) m_busy[I_lc_waddr] = 0;
      if (do_set) m_busy[I_id_rd_waddr] = 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge I_clk) begin
    if (check_en) begin
      logic [NRD*SELW-1:0] es;
      for (int k = 0; k < NRD; k++) es[k*SELW +: SELW] = SELW'(exp_sel(k));
      check("m_sel", O_fwd_sel, es);
      check("m_stall", O_stall, exp_lu() || exp_sb());
      check("m_busy", O_busy, m_busy_vec());
      check("m_pending", O_pending, m_pending());
      check("m_err", O_sb_err, m_err);
`ifdef FWD_SB_PERF_CNT_EN
      check("m_lu_cnt", O_lu_stall_cnt, m_lu_cnt);
      check("m_sb_cnt", O_sb_stall_cnt, m_sb_cnt);
`endif
    end
  end

  task automatic clr_in();
    I_rd_re = 0; I_rd_raddr = 0; I_fwd_we = 0; I_fwd_waddr = 0; I_fwd_rdy = '1;
    I_id_fire = 0; I_id_rd_we = 0; I_id_rd_waddr = 0; I_id_long = 0;
    I_lc_valid = 0; I_lc_waddr = 0;
  endtask

  task automatic fire_long(input logic [AW-1:0] rd);
    I_id_fire = 1; I_id_long = 1; I_id_rd_we = 1; I_id_rd_waddr = rd;
  endtask

  task automatic at_neg(); @(negedge I_clk); #1; endtask
  task automatic at_pos(); @(posedge I_clk); #1; endtask

  initial begin
    clr_in();
    I_rst_n = 0;
    repeat (2) at_pos();
    check_en = 1;
    I_rst_n = 1;
    at_neg();
    check("rst_busy", O_busy, 0);
    check("rst_pending", O_pending, 0);
    check("rst_err", O_sb_err, 0);

    // forward priority
    at_pos();
    I_rd_re = 2'b01; I_rd_raddr = {5'd0, 5'd5};
    I_fwd_we = 2'b11; I_fwd_waddr = {5'd5, 5'd5}; I_fwd_rdy = 2'b11;
    at_neg(); check("fwd_stage0", O_fwd_sel[1:0], 2);
    at_pos(); I_fwd_we = 2'b10;
    at_neg(); check("fwd_stage1", O_fwd_sel[1:0], 3);
    at_pos(); I_fwd_we = 2'b00;
    at_neg(); check("fwd_regfile", O_fwd_sel[1:0], 1);
    at_pos(); I_fwd_we = 2'b11; I_rd_raddr = 0; I_fwd_waddr = 0;
    at_neg(); check("fwd_r0_sel", O_fwd_sel[1:0], 0); check("fwd_r0_stall", O_stall, 0);

    // load-use
    at_pos(); clr_in();
    I_rd_re = 2'b10; I_rd_raddr = {5'd7, 5'd0};
    I_fwd_we = 2'b01; I_fwd_waddr = {5'd0, 5'd7}; I_fwd_rdy = 2'b10;
    at_neg(); check("lu_stall", O_stall, 1); check("lu_sel1", O_fwd_sel[3:2], 2);
    at_pos(); I_fwd_rdy = 2'b11;
    at_neg(); check("lu_release", O_stall, 0);

    // scoreboard RAW
    at_pos(); clr_in(); fire_long(5'd9);
    at_neg(); check("raw_issue_stall", O_stall, 0);
    at_pos(); clr_in(); I_rd_re = 2'b01; I_rd_raddr = {5'd0, 5'd9};
    at_neg(); check("raw_busy9", O_busy[9], 1); check("raw_pend1", O_pending, 1);
    check("raw_stall", O_stall, 1);
    at_pos(); I_lc_valid = 1; I_lc_waddr = 9;
    at_neg(); check("raw_stall_at_lc", O_stall, 1);
    at_pos(); I_lc_valid = 0;
    at_neg(); check("raw_release", O_stall, 0); check("raw_pend0", O_pending, 0);

    // WAW and same-cycle set/clear of different registers
    at_pos(); clr_in(); fire_long(5'd3);
    at_pos(); clr_in(); I_id_rd_we = 1; I_id_rd_waddr = 3;
    at_neg(); check("waw_stall", O_stall, 1);
    at_pos(); clr_in(); fire_long(5'd4); I_lc_valid = 1; I_lc_waddr = 3;
    at_neg(); check("setclr_stall", O_stall, 0);
    at_pos(); clr_in();
    at_neg(); check("setclr_busy", O_busy, 32'h10); check("setclr_pend", O_pending, 1);
    check("setclr_err", O_sb_err, 0);

    // errors
    at_pos(); I_lc_valid = 1; I_lc_waddr = 12;
    at_pos(); clr_in();
    at_neg(); check("err_nonbusy", O_sb_err, 1); check("err_nonbusy_busy", O_busy, 32'h10);
    at_pos(); I_rd_re = 2'b01; I_rd_raddr = {5'd0, 5'd4}; fire_long(5'd6);
    at_neg(); check("fire_stall", O_stall, 1);
    at_pos(); clr_in();
    at_neg(); check("fire_stall_noset", O_busy, 32'h10);
    at_pos(); fire_long(5'd8); I_lc_valid = 1; I_lc_waddr = 8;
    at_pos(); clr_in();
    at_neg(); check("same_reg_drop", O_busy, 32'h10); check("same_reg_pend", O_pending, 1);

    // reset mid-operation, then a stray completion
    at_pos(); I_rst_n = 0;
    at_pos(); I_rst_n = 1;
    at_neg(); check("rst2_busy", O_busy, 0); check("rst2_err", O_sb_err, 0);
    check("rst2_pend", O_pending, 0);
    at_pos(); I_lc_valid = 1; I_lc_waddr = 4;
    at_pos(); clr_in();
    at_neg(); check("post_rst_lc_err", O_sb_err, 1);

`ifdef FWD_SB_PERF_CNT_EN
    at_pos(); I_rst_n = 0;
    at_pos(); I_rst_n = 1;
    I_rd_re = 2'b10; I_rd_raddr = {5'd7, 5'd0};
    I_fwd_we = 2'b01; I_fwd_waddr = {5'd0, 5'd7}; I_fwd_rdy = 2'b10;
    repeat (3) at_pos();
    clr_in(); fire_long(5'd10);
    at_pos();
    clr_in(); I_rd_re = 2'b01; I_rd_raddr = {5'd0, 5'd10};
    repeat (4) at_pos();
    clr_in();
    at_neg(); check("perf_lu", O_lu_stall_cnt, 3); check("perf_sb", O_sb_stall_cnt, 4);
`endif

    at_pos();
    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-port forwarding selector.
- Generates per-read-port forwarding selects across NFWD pipeline stages for NRD read ports.
- Adds a register scoreboard for long-latency writers (div/mul/multi-cycle LSU), with RAW/WAW stall generation and load-use stall detection.
- Sits beside ID: consumes ID read addresses plus the EX/LS/WB write tags, and drives the ID-stage operand muxes and the pipeline stall.

Parameters:
NRD, 2, number of register read ports.
NFWD, 2, number of forwarding source stages; index 0 = youngest (nearest ID), highest priority.
AW, 5, register address width; NREG = 2**AW registers, register 0 hardwired zero.
SELW, $clog2(NFWD+2), width of each forward select field.
CNTW, 6, width of pending long-op counter.

Ports:
I_clk  in  1  clock
I_rst_n  in  1  synchronous active-low reset
I_rd_re  in  NRD  per-port read enable
I_rd_raddr  in  NRD*AW  per-port read address, port k at [k*AW +: AW]
I_fwd_we  in  NFWD  stage k writes a register
I_fwd_waddr  in  NFWD*AW  stage k destination
I_fwd_rdy  in  NFWD  stage k result available this cycle (0 = load still pending)
I_id_fire  in  1  ID instruction advances this cycle
I_id_rd_we  in  1  ID instruction writes rd
I_id_rd_waddr  in  AW  ID destination
I_id_long  in  1  ID instruction is long-latency (result returns via completion port)
I_lc_valid  in  1  long-latency completion (writes regfile this cycle)
I_lc_waddr  in  AW  completion destination
O_fwd_sel  out  NRD*SELW  per-port select: 0 nop, 1 regfile, 2+k stage k
O_stall  out  1  hold ID
O_busy  out  NREG  scoreboard busy vector
O_pending  out  CNTW  number of busy registers
O_sb_err  out  1  sticky protocol error

Behaviour:
- Reset (I_rst_n=0 at posedge): busy=0, O_pending=0, O_sb_err=0, counters=0. O_fwd_sel and O_stall are combinational; with busy=0 they follow the inputs.
- Select, per port k (combinational):
  - If !re or raddr==0: 0.
  - Else the lowest-index stage j with fwd_we[j] & waddr[j]==raddr gives 2+j.
  - Else 1.
- Load-use hazard: port k selects stage j and fwd_rdy[j]==0.
- Scoreboard RAW: a port with re & raddr!=0 & busy[raddr]==1. This takes precedence over forwarding; the port's select is still driven as computed.
- Scoreboard WAW: I_id_rd_we & waddr!=0 & busy[waddr].
- O_stall = OR of load-use, RAW and WAW hazards. It is purely combinational and uses the registered busy state (no same-cycle completion bypass), so a consumer stalls through the completion cycle and is released the cycle after.
- Set: at posedge, if I_id_fire & !O_stall & I_id_long & I_id_rd_we & waddr!=0, then busy[waddr]<=1.
- Clear: at posedge, if I_lc_valid & lc_waddr!=0, then busy[lc_waddr]<=0.
- Set and clear of different registers in the same cycle: both apply.
- Set and clear of the same register in the same cycle cannot occur legally, because WAW stalls the set. The clear is applied; the set is dropped and O_sb_err<=1.
- I_id_fire while O_stall=1: no state change, O_sb_err<=1.
- Completion to a non-busy register, or with lc_waddr==0: busy unchanged, O_sb_err<=1.
- O_pending: +1 on set, -1 on clear, unchanged when both occur. It saturates at 2**CNTW-1 and never underflows.
- O_sb_err clears only on reset.
- Reset asserted mid-operation: all busy bits drop, and in-flight completions after reset raise O_sb_err. Pipeline owners must squash long ops on reset.

Optional Feature:
- Macro FWD_SB_PERF_CNT_EN.
- Defined: adds outputs O_lu_stall_cnt[31:0] and O_sb_stall_cnt[31:0].
  - O_lu_stall_cnt increments each cycle a load-use hazard is present.
  - O_sb_stall_cnt increments each cycle a RAW or WAW hazard is present; a cycle with both hazard classes counts in both.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Forward priority, NFWD=2: port0 raddr=5, stage0 we/waddr=5, stage1 we/waddr=5, rdy=11 -> sel0=2. Drop stage0 -> sel0=3. Drop both -> sel0=1. raddr=0 -> sel0=0, no stall.
- Load-use: port1 raddr=7, stage0 writes 7 with rdy[0]=0 -> O_stall=1, sel1=2. rdy[0]=1 next cycle -> O_stall=0.
- Scoreboard RAW: fire long op rd=9 -> busy[9]=1 and O_pending=1 next cycle. Port0 reads 9 -> O_stall=1. I_lc_valid waddr=9 at cycle N -> stall still 1 at N, 0 at N+1, O_pending=0.
- WAW and same-cycle set/clear: busy[3]=1, ID rd_we waddr=3 -> O_stall=1. Force fire with a long op to rd=4 while lc clears rd=3 -> busy[4]=1, busy[3]=0, O_pending unchanged, O_sb_err=0.
- Errors: lc_valid to non-busy reg 12 -> O_sb_err=1 and busy unchanged. Fire during stall -> no set. Reset -> O_sb_err=0, busy=0.
- With FWD_SB_PERF_CNT_EN: 3 load-use cycles then 4 RAW cycles -> O_lu_stall_cnt=3, O_sb_stall_cnt=4.
